// File: rtl/mem_arb.sv
// Two-requester memory arbiter: IFU and LSU share one memory port, one transaction
// in flight, LSU has fixed priority with a starvation guard that forces an IFU grant.
module mem_arb #(
    parameter int XLEN           = 32,
    parameter int LSU_MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req,
    input  logic [XLEN-1:0]   ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [XLEN-1:0]   ifu_rdata,
    input  logic              lsu_req,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic              lsu_write,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic [XLEN/8-1:0] lsu_wstrb,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req and payload until it sees its gnt pulse; gnt
    // is only given in IDLE. Memory side: mem_req/payload hold until mem_gnt, then
    // exactly one mem_rvalid follows in a later cycle.

    localparam int SW = $clog2(LSU_MAX_CONSEC + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LSU_MAX_CONSEC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_lsu;
    logic [SW-1:0] streak;
    logic          lsu_win;
    logic          ifu_win;

    always_comb begin
        state_nxt  = state;
        ifu_gnt    = 1'b0;
        lsu_gnt    = 1'b0;
        ifu_rvalid = 1'b0;
        lsu_rvalid = 1'b0;
        // LSU yields only when IFU has waited through a full run of LSU grants.
        lsu_win    = lsu_req && !(ifu_req && (streak == STREAK_MAX));
        ifu_win    = ifu_req && !lsu_win;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (lsu_win) begin
                        lsu_gnt   = 1'b1;
                        state_nxt = REQ;
                    end else if (ifu_win) begin
                        ifu_gnt   = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) state_nxt = RESP;
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                    if (!rst) begin
                        if (owner_lsu) lsu_rvalid = 1'b1;
                        else           ifu_rvalid = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            streak    <= '0;
            mem_addr  <= '0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mem_rvalid && (state != RESP)) err <= 1'b1;
            if (lsu_gnt) begin
                owner_lsu <= 1'b1;
                mem_addr  <= lsu_addr;
                mem_write <= lsu_write;
                mem_wdata <= lsu_wdata;
                mem_wstrb <= lsu_wstrb;
                if (!ifu_req)                 streak <= '0;
                else if (streak != STREAK_MAX) streak <= streak + SW'(1);
            end else if (ifu_gnt) begin
                owner_lsu <= 1'b0;
                mem_addr  <= ifu_addr;
                mem_write <= 1'b0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
                streak    <= '0;
            end
        end
    end

    assign mem_req   = (state == REQ);
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: table of single transactions, then hand-written sequences for
// the starvation guard, streak clearing, spurious responses and reset in RESP.
module tb_mem_arb;
  localparam int XLEN = 32;
  localparam int W    = 2 + XLEN;
  localparam logic [1:0] S_IDLE = 2'd0;

  logic              clk, rst;
  logic              ifu_req, ifu_gnt, ifu_rvalid;
  logic [XLEN-1:0]   ifu_addr, ifu_rdata;
  logic              lsu_req, lsu_write, lsu_gnt, lsu_rvalid;
  logic [XLEN-1:0]   lsu_addr, lsu_wdata, lsu_rdata;
  logic [XLEN/8-1:0] lsu_wstrb;
  logic              mem_req, mem_write, mem_gnt, mem_rvalid, err;
  logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [1:0]        dbg_state;

  mem_arb #(.XLEN(XLEN), .LSU_MAX_CONSEC(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_write(lsu_write),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic            ifu_req;
    logic            lsu_req;
    logic [XLEN-1:0] ifu_addr;
    logic [XLEN-1:0] lsu_addr;
    logic            lsu_write;
    logic [XLEN-1:0] lsu_wdata;
    logic [3:0]      lsu_wstrb;
    int              gd;
    int              rd;
    logic [XLEN-1:0] rdata;
    logic            exp_lsu;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (ifu_rvalid || lsu_rvalid) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_rvalid: got ifu=%b lsu=%b expected none at %0t",
                 ifu_rvalid, lsu_rvalid, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rvalid_owner_data", 128'({ifu_rvalid, lsu_rvalid, ifu_rdata}), 128'(e));
      end
    end
  end

  // ---------------- driver ----------------
  // Entered just after a posedge with the DUT in IDLE and requests already driven.
  task automatic serve(input logic exp_lsu, input int gd, input int rd,
                       input logic [XLEN-1:0] rdata, input logic keep);
    logic [71:0] exp_pl;
    exp_pl = exp_lsu ? {1'b1, lsu_addr, lsu_write, lsu_wdata, lsu_wstrb, 2'b00}
                     : {1'b1, ifu_addr, 1'b0, 32'h0, 4'h0, 2'b00};
    @(negedge clk);
    check("grant", 128'({ifu_gnt, lsu_gnt, mem_req}), 128'({~exp_lsu, exp_lsu, 1'b0}));
    exp_q.push_back({~exp_lsu, exp_lsu, rdata});
    @(posedge clk); #1;
    if (!keep) begin ifu_req = 1'b0; lsu_req = 1'b0; end
    for (int i = 0; i < gd; i++) begin
      mem_gnt = 1'b0;
      @(negedge clk);
      check("req_payload_wait",
            128'({mem_req, mem_addr, mem_write, mem_wdata, mem_wstrb, ifu_gnt, lsu_gnt}),
            128'(exp_pl));
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    check("req_payload_gnt",
          128'({mem_req, mem_addr, mem_write, mem_wdata, mem_wstrb, ifu_gnt, lsu_gnt}),
          128'(exp_pl));
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      check("resp_wait", 128'({mem_req, ifu_gnt, lsu_gnt}), 128'(0));
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    check("response_delivered", 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  logic grant_order[10];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,   1'b0, 32'h0,        4'h0, 0, 1, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0,   32'h200, 1'b1, 32'h12345678, 4'hF, 3, 0, $urandom,     1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h0,   32'h300, 1'b0, 32'h0,        4'h0, 1, 2, $urandom,     1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'h400, 32'h500, 1'b0, 32'h0,        4'h0, 0, 0, $urandom,     1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h600, 32'h0,   1'b0, 32'h0,        4'h0, 2, 1, $urandom,     1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h700, 32'h704, 1'b1, $urandom,     4'h3, 0, 0, $urandom,     1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h708, 32'h70C, 1'b0, 32'h0,        4'h0, 1, 0, $urandom,     1'b1};
    vecs[7] = '{1'b0, 1'b1, 32'h0,   32'h710, 1'b1, $urandom,     4'hC, 0, 3, $urandom,     1'b1};
    vecs[8] = '{1'b1, 1'b1, 32'h800, 32'h804, 1'b0, 32'h0,        4'h0, 0, 1, $urandom,     1'b1};

    ifu_addr = '0; lsu_addr = '0; lsu_write = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_rdata = '0;

    // reset: requests and a response asserted while in reset must produce nothing
    rst = 1'b1; ifu_req = 1'b1; lsu_req = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    check("reset_gnt", 128'({ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid}), 128'(0));
    @(posedge clk); #1;
    ifu_req = 1'b0; lsu_req = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state",
          128'({dbg_state, mem_req, mem_addr, mem_write, mem_wdata, mem_wstrb, err}), 128'(0));
    @(posedge clk); #1;

    // table of single transactions
    for (int i = 0; i < 9; i++) begin
      ifu_req   = vecs[i].ifu_req;   lsu_req   = vecs[i].lsu_req;
      ifu_addr  = vecs[i].ifu_addr;  lsu_addr  = vecs[i].lsu_addr;
      lsu_write = vecs[i].lsu_write; lsu_wdata = vecs[i].lsu_wdata;
      lsu_wstrb = vecs[i].lsu_wstrb;
      serve(vecs[i].exp_lsu, vecs[i].gd, vecs[i].rd, vecs[i].rdata, 1'b0);
    end
    check("no_spurious_err", 128'(err), 128'(0));

    // starvation guard: both requests held throughout
    do_reset();
    grant_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ifu_req = 1'b1; lsu_req = 1'b1;
    ifu_addr = 32'h1000; lsu_addr = 32'h2000; lsu_write = 1'b0;
    lsu_wdata = '0; lsu_wstrb = '0;
    for (int i = 0; i < 10; i++)
      serve(grant_order[i], $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b1);
    ifu_req = 1'b0; lsu_req = 1'b0;

    // streak clear: an uncontended LSU grant restarts the count
    do_reset();
    ifu_req = 1'b1; lsu_req = 1'b1;
    serve(1'b1, 0, 0, $urandom, 1'b1);
    serve(1'b1, 0, 0, $urandom, 1'b1);
    ifu_req = 1'b0;
    serve(1'b1, 0, 0, $urandom, 1'b1);
    ifu_req = 1'b1;
    for (int i = 0; i < 4; i++) serve(1'b1, 0, 0, $urandom, 1'b1);
    serve(1'b0, 0, 0, $urandom, 1'b1);
    ifu_req = 1'b0; lsu_req = 1'b0;

    // spurious response in IDLE sets err, which is sticky until reset
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("spurious_err_set", 128'({err, dbg_state}), 128'({1'b1, S_IDLE}));
    @(posedge clk); #1;
    ifu_req = 1'b1; ifu_addr = 32'h3000;
    serve(1'b0, 1, 1, 32'hCAFEF00D, 1'b0);
    check("err_sticky", 128'(err), 128'(1));
    // response in the mem_gnt cycle is also out of protocol
    do_reset();
    check("err_cleared", 128'(err), 128'(0));
    lsu_req = 1'b1; lsu_addr = 32'h3100; lsu_write = 1'b0;
    @(negedge clk);
    check("early_rv_gnt", 128'(lsu_gnt), 128'(1));
    @(posedge clk); #1;
    lsu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    check("early_rv_err", 128'(err), 128'(1));

    // reset while in RESP drops the transaction
    do_reset();
    ifu_req = 1'b1; ifu_addr = 32'h4000;
    @(negedge clk);
    check("rresp_gnt", 128'(ifu_gnt), 128'(1));
    @(posedge clk); #1;
    ifu_req = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rresp_idle", 128'({dbg_state, mem_req, ifu_rvalid, lsu_rvalid}), 128'({S_IDLE, 3'b000}));
    @(posedge clk); #1;
    ifu_req = 1'b1; ifu_addr = 32'h4004;
    serve(1'b0, 0, 0, 32'h0BADF00D, 1'b0);

    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard bound on run length
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end
endmodule
